// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: state encodings and default sizing shared by the data-memory responder.
package dmem_responder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam int DEPTH_DEF = 1024;
  localparam int LATENCY_DEF = 4;
  function automatic int cnt_w(input int lat);
    return lat > 1 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port 32-bit RAM with write enable and registered read; kill drops a write or zeroes a read.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en,
  input  logic              we,
  input  logic              kill,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (en && we && !kill) mem[addr] <= wdata;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) rdata <= '0;
    else if (en && !we) rdata <= kill ? '0 : mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder that stalls the pipeline while an access is in flight.
// Optional misaligned-access check enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        error_o
);
  localparam int CW = cnt_w(LATENCY);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0] cap_data;
  logic cap_we, cap_kill, req, fire, mis;
  assign req = MemRead_i | MemWrite_i;
  assign fire = state == BUSY && cnt == '0;
  assign stall_o = (state == IDLE && req) || state == BUSY;
  assign ack_o = state == DONE;
`ifdef DMEM_MISALIGN_CHK_EN
  logic unused_addr;
  assign unused_addr = ^addr_i[31:ADDR_W+2];
  assign mis = |addr_i[1:0];
  assign error_o = state == DONE && cap_kill;
`else
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign mis = 1'b0;
  assign error_o = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (req ? BUSY : IDLE) :
               state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  // Request fields are latched only on acceptance, so input churn during BUSY is invisible.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt <= '0;
      cap_we <= 1'b0;
      cap_kill <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else if (state == IDLE && req) begin
      cnt <= CW'(LATENCY - 1);
      cap_we <= MemWrite_i;
      cap_kill <= mis;
      cap_addr <= addr_i[ADDR_W+1:2];
      cap_data <= data_i;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  dmem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en(fire),
    .we(cap_we),
    .kill(cap_kill),
    .addr(cap_addr),
    .wdata(cap_data),
    .rdata(data_o)
  );
endmodule
